// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit feeding a 2-entry output FIFO; result visible one cycle after accept, in_ready drops only when full.
// Optional per-entry zero/parity flag storage under LOGIC_UNIT_PIPE_FLAGS_EN; flags tie to 0 otherwise.
module logic_unit_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_sel,
    input  logic             clr_acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic [WIDTH-1:0] acc
);

    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] opa, res;
    logic             push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign opa       = acc_sel ? acc_q : a;
    assign acc       = acc_q;
    assign result    = out_valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        res = '0;
        case (op)
            3'b000:  res = '0;
            3'b001:  res = opa & b;
            3'b010:  res = opa | b;
            3'b011:  res = opa ^ b;
            3'b100:  res = ~(opa & b);
            3'b101:  res = ~(opa | b);
            3'b110:  res = ~(opa ^ b);
            default: res = ~opa;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            acc_q    <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= res;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            // Clear wins over the accept-time load; the operand already used the old value.
            if (clr_acc)
                acc_q <= '0;
            else if (push)
                acc_q <= res;
        end
    end

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    logic [1:0] zf_q, pf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q <= '0;
            pf_q <= '0;
        end else if (push) begin
            zf_q[wr_ptr_q] <= (res == '0);
            pf_q[wr_ptr_q] <= ^res;
        end
    end

    assign zero   = out_valid & zf_q[rd_ptr_q];
    assign parity = out_valid & pf_q[rd_ptr_q];
`else
    assign zero   = 1'b0;
    assign parity = 1'b0;
`endif

endmodule
